idex_stage: RTL and testbench
=============================

Name: idex_stage

Overview:
ID/EX pipeline register of the MIPS datapath, directly downstream of the register file. It captures the two register-file read values, the sign-extended immediate, the register indices, NPC and the decoded control bundles at each clock edge. It also detects load-use hazards, inserting a bubble and back-pressuring IF/ID. Supports an external stall (hold) and a flush (squash), with a valid bit tracking real instructions.

Parameters:
DATA_W, 32, width of data/NPC/immediate paths
REG_AW, 5, register index width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  downstream hold request; register keeps contents
flush  in  1  squash (branch taken); load bubble
id_valid  in  1  ID stage holds a real instruction
npc_in  in  DATA_W  next PC from IF/ID
readdat1  in  DATA_W  register file A (REG[rs])
readdat2  in  DATA_W  register file B (REG[rt])
signext_in  in  DATA_W  sign-extended immediate
rs_id  in  REG_AW  instr[25:21]
rt_id  in  REG_AW  instr[20:16]
rd_id  in  REG_AW  instr[15:11]
ctlwb_in  in  2  [1]=regwrite [0]=memtoreg
ctlm_in  in  3  [2]=branch [1]=memread [0]=memwrite
ctlex_in  in  4  [3]=regdst [2:1]=aluop [0]=alusrc
ex_valid  out  1  EX stage holds a real instruction
npc_out, rdata1_out, rdata2_out, signext_out  out  DATA_W  registered copies
rs_out, rt_out, rd_out  out  REG_AW  registered indices
ctlwb_out  out  2, ctlm_out  out  3, ctlex_out  out  4  registered controls
hazard_stall  out  1  load-use detected; IF/ID and PC must hold

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output 0, ex_valid=0. Release is synchronous to the next clk edge.
- hazard_stall is combinational. It is 1 iff ex_valid & ctlm_out[1] & (rt_out!=0) & id_valid & (rt_out==rs_id | rt_out==rt_id). Otherwise 0.
- Per-edge priority, highest first:
  1. flush=1: load bubble. All ctl outputs 0, ex_valid=0, data/index registers 0. Flush overrides stall.
  2. stall=1: hold every register. hazard_stall still reflects the current comparison.
  3. hazard_stall=1: load bubble as in 1. The ID instruction is not consumed. The next edge re-evaluates with the bubble in EX, so hazard_stall drops and the instruction loads. The load-use penalty is exactly 1 cycle.
  4. Otherwise: load all inputs. ex_valid<=id_valid. If id_valid=0, ctl outputs load 0 (data still loads).
- A bubble never asserts regwrite, memread, memwrite or branch downstream.
- Latency: input to output is 1 cycle. No combinational path from inputs to registered outputs.
- Index 0: rt_out==0 never raises a hazard, matching the hardwired-zero register.
- Reset asserted mid-stall or mid-hazard clears state immediately. hazard_stall=0 while in reset.
- Widths are pass-through only; no arithmetic except the optional counters.

Optional Feature:
IDEX_STATS_EN:
- Defined: adds outputs bubble_cnt and stall_cnt (32 bits each, reset 0).
  - bubble_cnt increments on every edge that loads a hazard bubble (priority 3).
  - stall_cnt increments on every edge with stall=1 and flush=0.
  - Both saturate at 0xFFFFFFFF.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with outputs nonzero -> all outputs 0 and ex_valid=0 before the next edge. Release, load readdat1=0x11, readdat2=0x22 -> rdata1_out=0x11, rdata2_out=0x22 after 1 edge.
- Load-use: EX holds lw (ctlm_out=3'b010, rt_out=8); ID has rs_id=8 -> hazard_stall=1, next edge ctl outputs 0 and ex_valid=0. Following edge hazard_stall=0 and the ID instruction loads.
- No false hazard: EX lw with rt_out=0 and rs_id=0 -> hazard_stall=0. EX has sw (ctlm_out=3'b001) with rt matching -> hazard_stall=0.
- Stall hold: load instruction with signext_in=0xFFFFFFF0, then stall=1 for 3 edges with changing inputs -> outputs unchanged throughout. Stall=0 -> new inputs appear after 1 edge.
- Flush priority: stall=1 and flush=1 on the same edge -> bubble loaded (ctlwb_out=0, ex_valid=0), not hold.
- With IDEX_STATS_EN: 2 hazard bubbles and 3 stall cycles -> bubble_cnt=2, stall_cnt=3.

Source files
------------

// File: rtl/idex_stage.sv
// -----------------------------------------------------------------------------
// idex_stage -- ID/EX pipeline register of the MIPS datapath.
//
// Captures register-file read data, sign-extended immediate, register indices,
// NPC and the decoded WB/M/EX control bundles on every rising clock edge.
// Detects load-use hazards against the instruction currently in ID, loading a
// bubble and asking IF/ID and the PC to hold for exactly one cycle.
//
// Per-edge priority: flush (bubble) > stall (hold) > hazard (bubble) > load.
//
// Optional feature macro: IDEX_STATS_EN
//   When defined, adds 32-bit saturating counters bubble_cnt (hazard bubbles)
//   and stall_cnt (edges with stall=1 and flush=0).
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   stall, flush        downstream hold request / squash
//   id_valid            ID holds a real instruction
//   npc_in, readdat1, readdat2, signext_in   data paths (DATA_W)
//   rs_id, rt_id, rd_id register indices (REG_AW)
//   ctlwb_in, ctlm_in, ctlex_in              control bundles (2/3/4 bits)
//   ex_valid            EX holds a real instruction
//   npc_out, rdata1_out, rdata2_out, signext_out, rs_out, rt_out, rd_out,
//   ctlwb_out, ctlm_out, ctlex_out           registered copies
//   hazard_stall        combinational load-use detect
//   bubble_cnt, stall_cnt (IDEX_STATS_EN only)
// -----------------------------------------------------------------------------
module idex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] npc_in,
   input  logic [DATA_W-1:0] readdat1,
   input  logic [DATA_W-1:0] readdat2,
   input  logic [DATA_W-1:0] signext_in,
   input  logic [REG_AW-1:0] rs_id,
   input  logic [REG_AW-1:0] rt_id,
   input  logic [REG_AW-1:0] rd_id,
   input  logic [1:0]        ctlwb_in,
   input  logic [2:0]        ctlm_in,
   input  logic [3:0]        ctlex_in,
   output logic              ex_valid,
   output logic [DATA_W-1:0] npc_out,
   output logic [DATA_W-1:0] rdata1_out,
   output logic [DATA_W-1:0] rdata2_out,
   output logic [DATA_W-1:0] signext_out,
   output logic [REG_AW-1:0] rs_out,
   output logic [REG_AW-1:0] rt_out,
   output logic [REG_AW-1:0] rd_out,
   output logic [1:0]        ctlwb_out,
   output logic [2:0]        ctlm_out,
   output logic [3:0]        ctlex_out,
   output logic              hazard_stall
`ifdef IDEX_STATS_EN
   ,
   output logic [31:0]       bubble_cnt,
   output logic [31:0]       stall_cnt
`endif
);

   logic              ex_valid_r;
   logic [DATA_W-1:0] npc_r, rdata1_r, rdata2_r, signext_r;
   logic [REG_AW-1:0] rs_r, rt_r, rd_r;
   logic [1:0]        ctlwb_r;
   logic [2:0]        ctlm_r;
   logic [3:0]        ctlex_r;

   logic              hazard_s;
   logic              bubble_s;
   logic              load_s;
   logic [1:0]        ctlwb_nxt_s;
   logic [2:0]        ctlm_nxt_s;
   logic [3:0]        ctlex_nxt_s;

   // Load-use detect plus the per-edge action select.
   always_comb begin
      hazard_s    = 1'b0;
      bubble_s    = 1'b0;
      load_s      = 1'b0;
      ctlwb_nxt_s = 2'b00;
      ctlm_nxt_s  = 3'b000;
      ctlex_nxt_s = 4'b0000;
      // rt==0 is the hardwired zero register, so it can never create a hazard.
      if (ex_valid_r && ctlm_r[1] && (rt_r != {REG_AW{1'b0}}) && id_valid &&
          ((rt_r == rs_id) || (rt_r == rt_id))) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
      if (flush) begin
         bubble_s = 1'b1;
      end else if (stall) begin
         bubble_s = 1'b0;
      end else if (hazard_s) begin
         bubble_s = 1'b1;
      end else begin
         load_s = 1'b1;
      end
      // An invalid ID slot still carries data but must not carry controls.
      if (id_valid) begin
         ctlwb_nxt_s = ctlwb_in;
         ctlm_nxt_s  = ctlm_in;
         ctlex_nxt_s = ctlex_in;
      end else begin
         ctlwb_nxt_s = 2'b00;
         ctlm_nxt_s  = 3'b000;
         ctlex_nxt_s = 4'b0000;
      end
   end

   // Pipeline register: bubble clears everything, load captures, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_r <= 1'b0;
         npc_r      <= {DATA_W{1'b0}};
         rdata1_r   <= {DATA_W{1'b0}};
         rdata2_r   <= {DATA_W{1'b0}};
         signext_r  <= {DATA_W{1'b0}};
         rs_r       <= {REG_AW{1'b0}};
         rt_r       <= {REG_AW{1'b0}};
         rd_r       <= {REG_AW{1'b0}};
         ctlwb_r    <= 2'b00;
         ctlm_r     <= 3'b000;
         ctlex_r    <= 4'b0000;
      end else if (bubble_s) begin
         ex_valid_r <= 1'b0;
         npc_r      <= {DATA_W{1'b0}};
         rdata1_r   <= {DATA_W{1'b0}};
         rdata2_r   <= {DATA_W{1'b0}};
         signext_r  <= {DATA_W{1'b0}};
         rs_r       <= {REG_AW{1'b0}};
         rt_r       <= {REG_AW{1'b0}};
         rd_r       <= {REG_AW{1'b0}};
         ctlwb_r    <= 2'b00;
         ctlm_r     <= 3'b000;
         ctlex_r    <= 4'b0000;
      end else if (load_s) begin
         ex_valid_r <= id_valid;
         npc_r      <= npc_in;
         rdata1_r   <= readdat1;
         rdata2_r   <= readdat2;
         signext_r  <= signext_in;
         rs_r       <= rs_id;
         rt_r       <= rt_id;
         rd_r       <= rd_id;
         ctlwb_r    <= ctlwb_nxt_s;
         ctlm_r     <= ctlm_nxt_s;
         ctlex_r    <= ctlex_nxt_s;
      end else begin
         ex_valid_r <= ex_valid_r;
         npc_r      <= npc_r;
         rdata1_r   <= rdata1_r;
         rdata2_r   <= rdata2_r;
         signext_r  <= signext_r;
         rs_r       <= rs_r;
         rt_r       <= rt_r;
         rd_r       <= rd_r;
         ctlwb_r    <= ctlwb_r;
         ctlm_r     <= ctlm_r;
         ctlex_r    <= ctlex_r;
      end
   end

   assign ex_valid     = ex_valid_r;
   assign npc_out      = npc_r;
   assign rdata1_out   = rdata1_r;
   assign rdata2_out   = rdata2_r;
   assign signext_out  = signext_r;
   assign rs_out       = rs_r;
   assign rt_out       = rt_r;
   assign rd_out       = rd_r;
   assign ctlwb_out    = ctlwb_r;
   assign ctlm_out     = ctlm_r;
   assign ctlex_out    = ctlex_r;
   assign hazard_stall = hazard_s;

`ifdef IDEX_STATS_EN
   logic [31:0] bubble_cnt_r;
   logic [31:0] stall_cnt_r;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

   // Saturating event counters; only hazard bubbles count, not flush bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_r <= 32'd0;
         stall_cnt_r  <= 32'd0;
      end else begin
         if (!flush && !stall && hazard_s) begin
            bubble_cnt_r <= sat_inc(bubble_cnt_r);
         end else begin
            bubble_cnt_r <= bubble_cnt_r;
         end
         if (stall && !flush) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign bubble_cnt = bubble_cnt_r;
   assign stall_cnt  = stall_cnt_r;
`endif

endmodule

// File: tb/tb_idex_stage.sv
// -----------------------------------------------------------------------------
// tb_idex_stage -- self-checking bench for idex_stage.
// A behavioural model of the EX slot is advanced on every edge and compared
// against the DUT on every falling edge; directed sections pin the model with
// hand-computed literal expectations, then a randomized run follows.
// -----------------------------------------------------------------------------
module tb_idex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, id_valid;
   logic [31:0] npc_in, readdat1, readdat2, signext_in;
   logic [4:0]  rs_id, rt_id, rd_id;
   logic [1:0]  ctlwb_in;
   logic [2:0]  ctlm_in;
   logic [3:0]  ctlex_in;
   logic        ex_valid;
   logic [31:0] npc_out, rdata1_out, rdata2_out, signext_out;
   logic [4:0]  rs_out, rt_out, rd_out;
   logic [1:0]  ctlwb_out;
   logic [2:0]  ctlm_out;
   logic [3:0]  ctlex_out;
   logic        hazard_stall;
`ifdef IDEX_STATS_EN
   logic [31:0] bubble_cnt, stall_cnt;
`endif

   int tests = 0;
   int fails = 0;

   idex_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
      .npc_in(npc_in), .readdat1(readdat1), .readdat2(readdat2), .signext_in(signext_in),
      .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
      .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
      .ex_valid(ex_valid), .npc_out(npc_out), .rdata1_out(rdata1_out),
      .rdata2_out(rdata2_out), .signext_out(signext_out),
      .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
      .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .ctlex_out(ctlex_out),
      .hazard_stall(hazard_stall)
`ifdef IDEX_STATS_EN
      , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model: contents of the EX slot ----------------
   typedef struct {
      bit          v;
      bit [31:0]   npc, r1, r2, se;
      bit [4:0]    rs, rt, rd;
      bit [1:0]    wb;
      bit [2:0]    m;
      bit [3:0]    ex;
   } slot_t;

   slot_t       ex_slot;
   slot_t       empty_slot;
   longint      m_bubbles = 0;
   longint      m_stalls  = 0;

   // A load in EX whose destination a valid ID instruction reads (never $zero).
   function automatic bit model_hazard();
      return ex_slot.v && (ex_slot.m == 3'b010 || ex_slot.m == 3'b011 ||
                           ex_slot.m == 3'b110 || ex_slot.m == 3'b111) &&
             ex_slot.rt != 5'd0 && id_valid === 1'b1 &&
             (ex_slot.rt == rs_id || ex_slot.rt == rt_id);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_slot   = empty_slot;
         m_bubbles = 0;
         m_stalls  = 0;
      end else if (flush) begin
         ex_slot = empty_slot;
      end else if (stall) begin
         m_stalls = m_stalls + 1;
      end else if (model_hazard()) begin
         ex_slot   = empty_slot;
         m_bubbles = m_bubbles + 1;
      end else begin
         ex_slot.v   = id_valid;
         ex_slot.npc = npc_in;
         ex_slot.r1  = readdat1;
         ex_slot.r2  = readdat2;
         ex_slot.se  = signext_in;
         ex_slot.rs  = rs_id;
         ex_slot.rt  = rt_id;
         ex_slot.rd  = rd_id;
         ex_slot.wb  = id_valid ? ctlwb_in : 2'b00;
         ex_slot.m   = id_valid ? ctlm_in  : 3'b000;
         ex_slot.ex  = id_valid ? ctlex_in : 4'b0000;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, ex_slot.v});
      chk("npc_out", npc_out, ex_slot.npc);
      chk("rdata1_out", rdata1_out, ex_slot.r1);
      chk("rdata2_out", rdata2_out, ex_slot.r2);
      chk("signext_out", signext_out, ex_slot.se);
      chk("idx_out", {17'd0, rs_out, rt_out, rd_out}, {17'd0, ex_slot.rs, ex_slot.rt, ex_slot.rd});
      chk("ctl_out", {23'd0, ctlwb_out, ctlm_out, ctlex_out}, {23'd0, ex_slot.wb, ex_slot.m, ex_slot.ex});
      chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, (rst_n === 1'b1) && model_hazard()});
`ifdef IDEX_STATS_EN
      chk("bubble_cnt", bubble_cnt, m_bubbles[31:0]);
      chk("stall_cnt", stall_cnt, m_stalls[31:0]);
`endif
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
      npc_in = 32'd0; readdat1 = 32'd0; readdat2 = 32'd0; signext_in = 32'd0;
      rs_id = 5'd0; rt_id = 5'd0; rd_id = 5'd0;
      ctlwb_in = 2'b00; ctlm_in = 3'b000; ctlex_in = 4'b0000;
   endtask

   task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] m);
      id_valid = 1'b1; rs_id = rs; rt_id = rt; rd_id = 5'd3;
      ctlwb_in = 2'b11; ctlm_in = m; ctlex_in = 4'b0011;
      npc_in = 32'h0000_0404; readdat1 = 32'h55; readdat2 = 32'h66; signext_in = 32'h4;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      empty_slot = '{default: '0};
      ex_slot    = empty_slot;
      rst_n      = 1'b0;
      idle_inputs();
      tick(); tick();
      rst_n = 1'b1;

      // Mid-cycle asynchronous reset while a hazard is showing.
      drive_instr(5'd1, 5'd8, 3'b010);
      tick();
      drive_instr(5'd8, 5'd2, 3'b000);
      chk("lit_pre_reset_hazard", {31'd0, hazard_stall}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("lit_async_rdata1", rdata1_out, 32'd0);
      chk("lit_async_ctlm", {29'd0, ctlm_out}, 32'd0);
      chk("lit_async_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("lit_async_hazard", {31'd0, hazard_stall}, 32'd0);
      tick();
      rst_n = 1'b1;
      drive_instr(5'd1, 5'd2, 3'b000);
      readdat1 = 32'h11; readdat2 = 32'h22;
      tick();
      chk("lit_load_r1", rdata1_out, 32'h11);
      chk("lit_load_r2", rdata2_out, 32'h22);

      // Load-use: lw rt=8 in EX, consumer rs=8 in ID.
      drive_instr(5'd1, 5'd8, 3'b010);
      tick();
      drive_instr(5'd8, 5'd4, 3'b000);
      npc_in = 32'h0000_0abc;
      chk("lit_lu_hazard", {31'd0, hazard_stall}, 32'd1);
      tick();
      chk("lit_lu_bubble_ctl", {23'd0, ctlwb_out, ctlm_out, ctlex_out}, 32'd0);
      chk("lit_lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
      chk("lit_lu_drop", {31'd0, hazard_stall}, 32'd0);
      tick();
      chk("lit_lu_loaded_rs", {27'd0, rs_out}, 32'd8);
      chk("lit_lu_loaded_npc", npc_out, 32'h0000_0abc);

      // No false hazard: lw with rt=0, and sw with matching rt.
      drive_instr(5'd0, 5'd0, 3'b010);
      tick();
      chk("lit_rt0_nohaz", {31'd0, hazard_stall}, 32'd0);
      drive_instr(5'd5, 5'd8, 3'b001);
      tick();
      drive_instr(5'd8, 5'd8, 3'b000);
      chk("lit_sw_nohaz", {31'd0, hazard_stall}, 32'd0);

      // Stall hold for 3 edges.
      drive_instr(5'd2, 5'd3, 3'b000);
      signext_in = 32'hFFFF_FFF0;
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         signext_in = 32'h100 + i;
         readdat1   = 32'h900 + i;
         tick();
         chk("lit_stall_hold_se", signext_out, 32'hFFFF_FFF0);
      end
      stall = 1'b0;
      signext_in = 32'h0000_1234;
      tick();
      chk("lit_stall_release_se", signext_out, 32'h0000_1234);

      // Flush overrides stall.
      stall = 1'b1; flush = 1'b1;
      tick();
      chk("lit_flush_wb", {30'd0, ctlwb_out}, 32'd0);
      chk("lit_flush_valid", {31'd0, ex_valid}, 32'd0);
      stall = 1'b0; flush = 1'b0;

      // Counter scenario: 2 hazard bubbles, 3 stall edges, from reset.
      idle_inputs();
      do_reset();
      drive_instr(5'd8, 5'd8, 3'b010);
      tick(); tick(); tick(); tick();
      id_valid = 1'b0;
      tick();
      stall = 1'b1;
      tick(); tick(); tick();
      stall = 1'b0;
`ifdef IDEX_STATS_EN
      chk("lit_bubble_cnt", bubble_cnt, 32'd2);
      chk("lit_stall_cnt", stall_cnt, 32'd3);
`endif
      chk("lit_cnt_model_bubbles", m_bubbles[31:0], 32'd2);
      chk("lit_cnt_model_stalls", m_stalls[31:0], 32'd3);

      // Randomized run with a small register index space to provoke hazards.
      for (int i = 0; i < 800; i++) begin
         id_valid   = ($urandom_range(0, 9) != 0);
         stall      = ($urandom_range(0, 5) == 0);
         flush      = ($urandom_range(0, 11) == 0);
         rs_id      = 5'($urandom_range(0, 3));
         rt_id      = 5'($urandom_range(0, 3));
         rd_id      = 5'($urandom_range(0, 31));
         ctlwb_in   = 2'($urandom_range(0, 3));
         ctlm_in    = 3'($urandom_range(0, 7));
         ctlex_in   = 4'($urandom_range(0, 15));
         npc_in     = $urandom;
         readdat1   = $urandom;
         readdat2   = $urandom;
         signext_in = $urandom;
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            #3 rst_n = 1'b1;
         end
         tick();
      end

      idle_inputs();
      tick(); tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
